// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/ALU encodings, sequencer state enum and ALU decode helper
package ctrl_pkg;
  localparam int CNTW = 8;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_BEQ   = 4'd10;
  localparam logic [3:0] OP_BNE   = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_AES   = 4'd13;
  localparam logic [3:0] OP_I2C   = 4'd14;
  localparam logic [3:0] OP_MUL   = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, COP_WAIT} state_t;

  typedef struct packed {
    logic       mode;
    logic [2:0] op;
  } alu_ctrl_t;

  // BEQ/BNE use the compare selects 1 and 2; the ALU applies its own sense
  function automatic alu_ctrl_t decodeAlu(input logic [3:0] opc);
    logic [3:0] rel;
    rel = opc - OP_ADD;
    return (opc >= OP_ADD && opc <= OP_SLT) ? {1'b1, rel[2:0]} :
           (opc == OP_BEQ) ? {1'b0, ALU_SUB} :
           (opc == OP_BNE) ? {1'b0, ALU_AND} :
           (opc == OP_MUL) ? {1'b1, ALU_ADD} : {1'b0, ALU_ADD};
  endfunction
endpackage

// File: rtl/cop_timeout_timer.sv
// cop_timeout_timer: 8-bit coprocessor wait counter, expired in the wait cycle that reaches COP_TIMEOUT
module cop_timeout_timer
  import ctrl_pkg::*;
#(
  parameter int COP_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [CNTW-1:0] count, countNext;

  assign countNext = count + 1'b1;
  assign expired = en && countNext == CNTW'(COP_TIMEOUT);

  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= countNext;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/exec/mem/write-back control FSM with coprocessor start/done handshakes
// Defining INSTR_SEQUENCER_PERF_EN adds retired_cnt and stall_cnt outputs.
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW = 4,
  parameter int COP_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           instr_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           branch_taken,
  input  logic           aes_done,
  input  logic           i2c_done,
  input  logic           mul_done,
  output logic           fetch_req,
  output logic           alu_mode,
  output logic [2:0]     alu_op,
  output logic           exec_start,
  output logic           mem_read,
  output logic           mem_write,
  output logic           write_back,
  output logic           pc_load,
  output logic           aes_start,
  output logic           i2c_start,
  output logic           mul_start,
  output logic           busy,
  output logic           err_timeout
`ifdef INSTR_SEQUENCER_PERF_EN
  ,
  output logic [31:0]    retired_cnt,
  output logic [31:0]    stall_cnt
`endif
);
  state_t state, nextState, endState;
  logic [OPW-1:0] opReg;
  logic isLoad, isStore, isAlu, isBranch, isJump, isCop, copDone, copExpired;

  assign isLoad   = opReg == OP_LOAD;
  assign isStore  = opReg == OP_STORE;
  assign isAlu    = opReg >= OP_ADD && opReg <= OP_SLT;
  assign isBranch = opReg == OP_BEQ || opReg == OP_BNE;
  assign isJump   = opReg == OP_JMP;
  assign isCop    = opReg >= OP_AES;
  assign copDone  = (opReg == OP_AES && aes_done) || (opReg == OP_I2C && i2c_done) ||
                    (opReg == OP_MUL && mul_done);
  assign endState = run ? FETCH : IDLE;

  cop_timeout_timer #(.COP_TIMEOUT(COP_TIMEOUT)) timer (
    .clk(clk),
    .reset(reset),
    .clear(state == EXEC),
    .en(state == COP_WAIT),
    .expired(copExpired)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = run ? FETCH : IDLE;
      FETCH:    nextState = instr_valid ? DECODE : run ? FETCH : IDLE;
      DECODE:   nextState = EXEC;
      EXEC:     nextState = (isLoad || isStore) ? MEM : isAlu ? WB : isCop ? COP_WAIT : endState;
      MEM:      nextState = isLoad ? WB : endState;
      WB:       nextState = endState;
      COP_WAIT: nextState = (copDone && opReg == OP_MUL) ? WB : (copDone || copExpired) ? endState : COP_WAIT;
      default:  nextState = IDLE;
    endcase
  end

  // Strobes are registered from nextState so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      opReg       <= '0;
      fetch_req   <= 1'b0;
      alu_mode    <= 1'b0;
      alu_op      <= '0;
      exec_start  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      write_back  <= 1'b0;
      pc_load     <= 1'b0;
      aes_start   <= 1'b0;
      i2c_start   <= 1'b0;
      mul_start   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= nextState;
      if (fetch_req && instr_valid) opReg <= opcode;
      if (state == DECODE) {alu_mode, alu_op} <= decodeAlu(opReg);
      fetch_req   <= nextState == FETCH;
      exec_start  <= nextState == EXEC;
      mem_read    <= nextState == MEM && isLoad;
      mem_write   <= nextState == MEM && isStore;
      write_back  <= nextState == WB;
      pc_load     <= state == EXEC && (isJump || (isBranch && branch_taken));
      aes_start   <= state == EXEC && opReg == OP_AES;
      i2c_start   <= state == EXEC && opReg == OP_I2C;
      mul_start   <= state == EXEC && opReg == OP_MUL;
      busy        <= nextState != IDLE;
      err_timeout <= err_timeout || (state == COP_WAIT && copExpired && !copDone);
    end

`ifdef INSTR_SEQUENCER_PERF_EN
  logic retire;
  assign retire = (state inside {EXEC, MEM, WB, COP_WAIT}) && (nextState inside {FETCH, IDLE});

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      if (state == COP_WAIT || (state == FETCH && !instr_valid)) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: vector table plus hand sequences, checked through an expected-value queue
// Two instances share stimulus: [0] default COP_TIMEOUT, [1] COP_TIMEOUT=5.
module tb_instr_sequencer;
  typedef struct packed {
    logic       run;
    logic       iv;
    logic [3:0] op;
    logic       bt;
    logic [2:0] dn;
    logic [14:0] exp;
  } vec_t;

  localparam logic [14:0] FR = 15'h4000, MD = 15'h2000, EX = 15'h0200, RD = 15'h0100;
  localparam logic [14:0] WR = 15'h0080, WB = 15'h0040, PC = 15'h0020, AS = 15'h0010;
  localparam logic [14:0] IS = 15'h0008, MS = 15'h0004, BZ = 15'h0002, ER = 15'h0001;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, iv = 1'b0, bt = 1'b0;
  logic aesDone = 1'b0, i2cDone = 1'b0, mulDone = 1'b0;
  logic [3:0] opcode = '0;
  logic [1:0] fetchReq, aluMode, execStart, memRead, memWrite, writeBack, pcLoad;
  logic [1:0] aesStart, i2cStart, mulStart, busy, errTimeout;
  logic [1:0][2:0] aluOp;
  logic [1:0][14:0] obs;
  logic [14:0] sb[$];
  vec_t vecs[$];
  int nVec = 0, nBad = 0, idx = 0, sel = 0;
  string phase = "";

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
`ifdef INSTR_SEQUENCER_PERF_EN
    logic [31:0] retired, stall;
`endif
    instr_sequencer #(.COP_TIMEOUT(g == 0 ? 255 : 5)) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .instr_valid(iv),
      .opcode(opcode),
      .branch_taken(bt),
      .aes_done(aesDone),
      .i2c_done(i2cDone),
      .mul_done(mulDone),
      .fetch_req(fetchReq[g]),
      .alu_mode(aluMode[g]),
      .alu_op(aluOp[g]),
      .exec_start(execStart[g]),
      .mem_read(memRead[g]),
      .mem_write(memWrite[g]),
      .write_back(writeBack[g]),
      .pc_load(pcLoad[g]),
      .aes_start(aesStart[g]),
      .i2c_start(i2cStart[g]),
      .mul_start(mulStart[g]),
      .busy(busy[g]),
      .err_timeout(errTimeout[g])
`ifdef INSTR_SEQUENCER_PERF_EN
      ,
      .retired_cnt(retired),
      .stall_cnt(stall)
`endif
    );
    assign obs[g] = {fetchReq[g], aluMode[g], aluOp[g], execStart[g], memRead[g], memWrite[g],
                     writeBack[g], pcLoad[g], aesStart[g], i2cStart[g], mulStart[g], busy[g], errTimeout[g]};
  end

  function automatic vec_t vv(input logic r, input logic v, input logic [3:0] o, input logic b,
                              input logic [2:0] d, input logic [14:0] e);
    return {r, v, o, b, d, e};
  endfunction

  function automatic logic [14:0] ao(input int n);
    return 15'(n) << 10;
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    nVec++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic step(input vec_t v);
    logic [14:0] want;
    run = v.run;
    iv = v.iv;
    opcode = v.op;
    bt = v.bt;
    {aesDone, i2cDone, mulDone} = v.dn;
    sb.push_back(v.exp);
    @(negedge clk);
    want = sb.pop_front();
    check($sformatf("%s[%0d]", phase, idx), obs[sel], want);
    idx++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    {run, iv, bt, aesDone, i2cDone, mulDone} = '0;
    opcode = '0;
    #1;
    check({phase, ":rst0"}, obs[0], '0);
    check({phase, ":rst1"}, obs[1], '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    phase = "init";
    doReset();

    // run, iv, op, bt, {aes,i2c,mul}_done, expected outputs after the edge
    vecs.push_back(vv(0, 0, 4'd0,  0, 3'b000, '0));
    vecs.push_back(vv(1, 1, 4'd3,  0, 3'b000, FR | BZ));
    vecs.push_back(vv(1, 1, 4'd3,  0, 3'b000, BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, MD | ao(1) | EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, MD | ao(1) | WB | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, MD | ao(1) | FR | BZ));
    vecs.push_back(vv(1, 1, 4'd0,  0, 3'b000, MD | ao(1) | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, RD | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, WB | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    vecs.push_back(vv(1, 1, 4'd10, 0, 3'b000, BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, ao(1) | EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  1, 3'b000, ao(1) | FR | PC | BZ));
    vecs.push_back(vv(1, 1, 4'd11, 0, 3'b000, ao(1) | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  1, 3'b000, ao(2) | EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, ao(2) | FR | BZ));
    vecs.push_back(vv(1, 1, 4'd12, 0, 3'b000, ao(2) | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, FR | PC | BZ));
    vecs.push_back(vv(1, 1, 4'd1,  0, 3'b000, BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, WR | BZ));
    vecs.push_back(vv(0, 0, 4'd0,  0, 3'b000, '0));
    vecs.push_back(vv(0, 1, 4'd5,  0, 3'b000, '0));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    vecs.push_back(vv(0, 0, 4'd0,  0, 3'b000, '0));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    vecs.push_back(vv(1, 1, 4'd9,  0, 3'b000, BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, MD | ao(7) | EX | BZ));
    vecs.push_back(vv(1, 0, 4'd0,  0, 3'b000, MD | ao(7) | WB | BZ));
    vecs.push_back(vv(0, 0, 4'd0,  0, 3'b000, MD | ao(7)));

    phase = "table";
    sel = 0;
    foreach (vecs[i]) step(vecs[i]);

    phase = "aes";
    doReset();
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    step(vv(1, 1, 4'd13, 0, 3'b000, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, AS | BZ));
    for (int i = 0; i < 9; i++) step(vv(1, 0, 4'd0, 0, 3'b011, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b100, FR | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));

    phase = "timeout";
    sel = 1;
    doReset();
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    step(vv(1, 1, 4'd14, 0, 3'b000, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, IS | BZ));
    for (int i = 0; i < 4; i++) step(vv(1, 0, 4'd0, 0, 3'b101, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b101, FR | BZ | ER));
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ | ER));
    step(vv(1, 1, 4'd2,  0, 3'b000, BZ | ER));
    step(vv(1, 0, 4'd0,  0, 3'b000, MD | EX | BZ | ER));

    phase = "collide";
    doReset();
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    step(vv(1, 1, 4'd15, 0, 3'b000, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, MD | EX | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, MD | MS | BZ));
    for (int i = 0; i < 4; i++) step(vv(1, 0, 4'd0, 0, 3'b110, MD | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b001, MD | WB | BZ));
    step(vv(0, 0, 4'd0,  0, 3'b000, MD));

    phase = "midrst";
    sel = 0;
    doReset();
    step(vv(1, 0, 4'd0,  0, 3'b000, FR | BZ));
    step(vv(1, 1, 4'd1,  0, 3'b000, BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, EX | BZ));
    step(vv(1, 0, 4'd0,  0, 3'b000, WR | BZ));
    #1 reset = 1'b1;
    #1;
    check("midrst:drop0", obs[0], '0);
    check("midrst:drop1", obs[1], '0);
    @(negedge clk);
    reset = 1'b0;
    step(vv(0, 0, 4'd0,  0, 3'b000, '0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
